// File: rtl/result_logger_if.sv
// Bundles the observed CPU result bus and the FIFO read port of result_logger.
// The master side drives the observed bus and consumes the log; the slave side is the logger.
interface result_logger_if #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 16
);
    logic [DATA_W-1:0]          result_in;
    logic                       capture_en;
    logic                       clear;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [TS_W+DATA_W-1:0]     rd_data;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;

    modport master (
        output result_in,
        output capture_en,
        output clear,
        output rd_ready,
        input  rd_valid,
        input  rd_data,
        input  count,
        input  overflow
    );

    modport slave (
        input  result_in,
        input  capture_en,
        input  clear,
        input  rd_ready,
        output rd_valid,
        output rd_data,
        output count,
        output overflow
    );
endinterface

// File: rtl/result_logger.sv
// Passive observer of the CPU result bus: logs every new value with a cycle
// timestamp into a show-ahead FIFO that a downstream consumer drains in order.
module result_logger #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    result_logger_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + DATA_W;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic [TS_W-1:0]   r_ts;
    logic [DATA_W-1:0] r_prev;

    logic              w_wantPush;
    logic              w_tsInc;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic              w_valid;

    // Decide the next capture state and whether this cycle produces a sample.
    always_comb begin
        w_nextState = r_state;
        w_wantPush  = 1'b0;
        w_tsInc     = 1'b0;
        if (bus.clear) begin
            w_nextState = bus.capture_en ? PRIME : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.capture_en) begin
                        w_nextState = PRIME;
                    end
                end
                PRIME: begin
                    if (!bus.capture_en) begin
                        w_nextState = IDLE;
                    end else begin
                        w_wantPush  = 1'b1;
                        w_tsInc     = 1'b1;
                        w_nextState = RUN;
                    end
                end
                RUN: begin
                    if (!bus.capture_en) begin
                        w_nextState = IDLE;
                    end else begin
                        w_wantPush = (bus.result_in != r_prev);
                        w_tsInc    = 1'b1;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == FULL_COUNT);
        w_pop   = w_valid && bus.rd_ready && !bus.clear;
        w_push  = w_wantPush && (!w_full || w_pop);
        w_drop  = w_wantPush && w_full && !w_pop;
    end

    // Capture state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pointers, occupancy, sticky overflow, timestamp and last-seen value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ts       <= '0;
            r_prev     <= '0;
        end else if (bus.clear) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ts       <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_tsInc) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_wantPush) begin
                r_prev <= bus.result_in;
            end
        end
    end

    // Storage array; slots are only ever read while they hold valid data, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push && rst) begin
            r_mem[r_wrPtr] <= {r_ts, bus.result_in};
        end
    end

    assign bus.rd_valid = w_valid;
    assign bus.rd_data  = w_valid ? r_mem[r_rdPtr] : '0;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_result_logger.sv
// Self-checking bench for result_logger: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_result_logger;
    localparam int DATA_W = 16;
    localparam int TS_W   = 16;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst;

    result_logger_if #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) bus ();

    result_logger #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount;
    int passCount;

    // Reference model: the log is a queue; loggingMode 0 = off,
    // 1 = enabled and waiting to log the first value, 2 = logging changes.
    logic [31:0] modelQ[$];
    logic [15:0] modelTs;
    logic [15:0] modelPrev;
    int          loggingMode;
    logic        modelOvf;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelTs     = '0;
        modelPrev   = '0;
        loggingMode = 0;
        modelOvf    = 1'b0;
    endtask

    task automatic modelStep(input logic en, input logic clr, input logic [15:0] rin, input logic rdy);
        logic popOk;
        logic doLog;
        popOk = (modelQ.size() != 0) && rdy;
        doLog = 1'b0;
        if (clr) begin
            modelQ.delete();
            modelOvf    = 1'b0;
            modelTs     = '0;
            loggingMode = en ? 1 : 0;
        end else begin
            if (!en) begin
                loggingMode = 0;
            end else if (loggingMode == 0) begin
                loggingMode = 1;
            end else begin
                doLog = (loggingMode == 1) || (rin != modelPrev);
                loggingMode = 2;
                if (doLog) begin
                    modelPrev = rin;
                end
            end
            if (popOk) begin
                void'(modelQ.pop_front());
            end
            if (doLog) begin
                if (modelQ.size() < DEPTH) begin
                    modelQ.push_back({modelTs, rin});
                end else begin
                    modelOvf = 1'b1;
                end
            end
            if (en && loggingMode == 2) begin
                modelTs = modelTs + 16'd1;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("rd_valid", 32'(bus.rd_valid), 32'(modelQ.size() != 0));
        checkOutput("count", 32'(bus.count), 32'(modelQ.size()));
        checkOutput("overflow", 32'(bus.overflow), 32'(modelOvf));
        checkOutput("rd_data", bus.rd_data, (modelQ.size() != 0) ? modelQ[0] : 32'h0);
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic [15:0] rin, input logic rdy);
        bus.capture_en = en;
        bus.clear      = clr;
        bus.result_in  = rin;
        bus.rd_ready   = rdy;
        @(posedge clk);
        modelStep(en, clr, rin, rdy);
        #1;
        compareAll();
    endtask

    logic [31:0] chgExpect [3];

    initial begin
        checkCount = 0;
        passCount  = 0;
        modelReset();
        rst            = 1'b0;
        bus.capture_en = 1'b0;
        bus.clear      = 1'b0;
        bus.result_in  = '0;
        bus.rd_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compareAll();
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        rst = 1'b1;

        // Reset then enable: first value after enable is logged at timestamp 0.
        applyStimulus(1'b1, 1'b0, 16'h0005, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0005, 1'b0);
        checkOutput("enable_count", 32'(bus.count), 32'd1);
        checkOutput("enable_entry", bus.rd_data, 32'h0000_0005);

        // Change detection: 5,7,7,7,9 follow the primed 5.
        applyStimulus(1'b1, 1'b0, 16'h0005, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0007, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0007, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0007, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0009, 1'b0);
        checkOutput("chg_count", 32'(bus.count), 32'd3);
        chgExpect[0] = 32'h0000_0005;
        chgExpect[1] = 32'h0002_0007;
        chgExpect[2] = 32'h0005_0009;
        for (int i = 0; i < 3; i++) begin
            checkOutput("chg_read", bus.rd_data, chgExpect[i]);
            applyStimulus(1'b0, 1'b0, 16'h0009, 1'b1);
        end
        checkOutput("chg_empty", 32'(bus.rd_valid), 32'd0);

        // Overflow: 20 distinct values into a 16-deep FIFO with no reads.
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
        end
        checkOutput("ovf_count", 32'(bus.count), 32'd16);
        checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_head", bus.rd_data, 32'h0000_0100);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
        checkOutput("clr_count", 32'(bus.count), 32'd0);
        checkOutput("clr_flag", 32'(bus.overflow), 32'd0);
        checkOutput("clr_valid", 32'(bus.rd_valid), 32'd0);

        // Full FIFO with simultaneous push and pop.
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0200 + 16'(i), 1'b0);
        end
        checkOutput("full_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0300 + 16'(i), 1'b1);
            checkOutput("fullpop_count", 32'(bus.count), 32'd16);
        end
        checkOutput("fullpop_head", bus.rd_data, 32'h000A_020A);
        checkOutput("fullpop_ovf", 32'(bus.overflow), 32'd0);

        // Disable/re-enable: timestamp freezes while disabled, first value is re-primed.
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0011, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0022, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0033, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0044, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0055, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0066, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0077, 1'b0);
        checkOutput("dis_count", 32'(bus.count), 32'd3);
        applyStimulus(1'b1, 1'b0, 16'h0088, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0099, 1'b0);
        checkOutput("reen_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0099, 1'b1);
        end
        checkOutput("reen_entry", bus.rd_data, 32'h0003_0099);

        // Randomized traffic with repeats, occasional clears and varying read pressure.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) != 0,
                          $urandom_range(0, 59) == 0,
                          16'($urandom_range(0, 3)),
                          (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset between clock edges with six entries held.
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0500 + 16'(i), 1'b0);
        end
        checkOutput("pre_rst_count", 32'(bus.count), 32'd6);
        #3;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("arst_count", 32'(bus.count), 32'd0);
        checkOutput("arst_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("arst_ovf", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        compareAll();
        rst = 1'b1;

        // Recovery after reset.
        applyStimulus(1'b1, 1'b0, 16'h0ABC, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0ABC, 1'b0);
        checkOutput("recover_entry", bus.rd_data, 32'h0000_0ABC);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
